stream_packet_arbiter: RTL and testbench
========================================

STREAM_PACKET_ARBITER -- requirements
Module: stream_packet_arbiter

Interface
REQ-001 Parameter C_AXIS_TDATA_WIDTH, default 32: data width of all stream ports.
REQ-002 Port pixel_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Ports s00_axis_tvalid/tlast  input  1 each; s00_axis_tdata  input  C_AXIS_TDATA_WIDTH; s00_axis_tstrb  input  C_AXIS_TDATA_WIDTH/8; s00_axis_tready  output  1: requester 0 stream.
REQ-005 Ports s01_axis_* (same set, same widths and directions): requester 1 stream.
REQ-006 Ports m00_axis_tvalid/tlast  output  1 each; m00_axis_tdata  output  C_AXIS_TDATA_WIDTH; m00_axis_tstrb  output  C_AXIS_TDATA_WIDTH/8; m00_axis_tready  input  1: shared downstream (DMA) stream.
REQ-007 Port grant  output  2  one-hot current owner: 2'b01 = s00, 2'b10 = s01, 2'b00 = none.
REQ-008 Ports pkt_count0, pkt_count1  output  16 each: completed packets forwarded from s00 / s01.

Function
REQ-009 The block SHALL share m00 between s00 and s01 at packet granularity; a packet is never interleaved with the other requester's beats.
REQ-010 FSM states: IDLE, GRANT0, GRANT1; state, last_grant, pkt_count0/1 are the only registers.
REQ-011 IDLE: only s00_axis_tvalid high -> GRANT0 next cycle; only s01 high -> GRANT1; both high -> port != last_grant; neither -> stay IDLE.
REQ-012 IDLE: m00_axis_tvalid = 0, both s*_axis_tready = 0, grant = 2'b00; no beat transfers in IDLE.
REQ-013 GRANTn: m00_axis_tvalid/tlast/tdata/tstrb combinationally equal s0n_axis_*; s0n_axis_tready = m00_axis_tready; the other requester's tready = 0.
REQ-014 Handshake = m00_axis_tvalid && m00_axis_tready in a GRANT state.
REQ-015 GRANTn stays until a handshake with m00_axis_tlast = 1; then next state IDLE, last_grant <= n, pkt_count(n) += 1.
REQ-016 pkt_count wrap: 16'hFFFF + 1 -> 16'h0000, no saturation, no flag.
REQ-017 Arbitration latency: one IDLE cycle before first beat of every packet (including back-to-back packets); tvalid high in IDLE -> first beat earliest on next cycle.
REQ-018 Requester deasserting tvalid mid-packet SHALL NOT release grant; block holds GRANTn indefinitely until tlast handshake (no timeout).
REQ-019 Requester dropping tvalid while in IDLE before grant: decision uses current-cycle tvalid only; no request latching.
REQ-020 Single-beat packet (tlast on first beat) SHALL complete normally: one beat, count += 1, IDLE next cycle.
REQ-021 tdata/tstrb/tlast of non-granted port ignored; m00 data in IDLE drives all zeros.
REQ-022 No combinational path from s*_axis_tvalid to s*_axis_tready; tready depends only on state and m00_axis_tready.

Reset
REQ-023 rst high SHALL immediately (asynchronously) force state = IDLE, last_grant = 1 (so s00 wins first tie), pkt_count0 = pkt_count1 = 0.
REQ-024 During and right after reset: m00_axis_tvalid = 0, m00_axis_tlast = 0, grant = 2'b00, both s*_axis_tready = 0.
REQ-025 Reset mid-packet SHALL abandon the packet (no tlast emitted, count not incremented); arbitration restarts from IDLE after rst deasserts.

Verification
REQ-026 Both tvalid high from reset, 4-beat packets each, m00_axis_tready = 1 -> s00 packet (beats 1-4, tlast on 4th), 1 IDLE cycle, s01 packet; pkt_count0 = pkt_count1 = 1.
REQ-027 Only s01 sending 3 consecutive 2-beat packets -> each granted to s01, one idle cycle between packets, pkt_count1 = 3, pkt_count0 = 0.
REQ-028 GRANT0, m00_axis_tready toggling 1/0 and s00 tvalid dropping mid-packet -> no beat lost or duplicated, s01_axis_tready stays 0, grant stays 2'b01 until tlast handshake.
REQ-029 Force pkt_count0 to 16'hFFFF via 65535 single-beat packets, send one more -> pkt_count0 = 16'h0000.
REQ-030 Assert rst on beat 2 of a 5-beat s01 packet -> m00_axis_tvalid = 0 same cycle, pkt_count1 = 0, after release with both requesting s00 granted first.

Source files
------------

// File: rtl/stream_packet_arbiter.sv
// Two-requester AXI-Stream packet arbiter: hands the shared m00 stream to
// s00 or s01 one whole packet at a time, alternating on ties, and counts
// the packets completed for each requester.
module stream_packet_arbiter #(
    parameter int C_AXIS_TDATA_WIDTH = 32
) (
    input  logic                            pixel_clk,
    input  logic                            rst,

    input  logic                            s00_axis_tvalid,
    input  logic                            s00_axis_tlast,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    output logic                            s00_axis_tready,

    input  logic                            s01_axis_tvalid,
    input  logic                            s01_axis_tlast,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s01_axis_tstrb,
    output logic                            s01_axis_tready,

    output logic                            m00_axis_tvalid,
    output logic                            m00_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    input  logic                            m00_axis_tready,

    output logic [1:0]                      grant,
    output logic [15:0]                     pkt_count0,
    output logic [15:0]                     pkt_count1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    // Requester that finished the most recent packet: 0 = s00, 1 = s01.
    logic   last_grant;
    logic   handshake;

    assign handshake = m00_axis_tvalid && m00_axis_tready;

    // Arbitration FSM: pick an owner in IDLE, hold it until its tlast beat
    // is accepted, then record the winner and bump its packet counter.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            pkt_count0 <= 16'h0000;
            pkt_count1 <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (s00_axis_tvalid && s01_axis_tvalid)
                        state <= last_grant ? GRANT0 : GRANT1;
                    else if (s00_axis_tvalid)
                        state <= GRANT0;
                    else if (s01_axis_tvalid)
                        state <= GRANT1;
                end
                GRANT0: begin
                    if (handshake && m00_axis_tlast) begin
                        state      <= IDLE;
                        last_grant <= 1'b0;
                        pkt_count0 <= pkt_count0 + 16'd1;
                    end
                end
                GRANT1: begin
                    if (handshake && m00_axis_tlast) begin
                        state      <= IDLE;
                        last_grant <= 1'b1;
                        pkt_count1 <= pkt_count1 + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output steering: the owner's stream passes straight through; tready
    // is a function of state and downstream ready only, never of tvalid.
    always_comb begin
        m00_axis_tvalid = 1'b0;
        m00_axis_tlast  = 1'b0;
        m00_axis_tdata  = '0;
        m00_axis_tstrb  = '0;
        s00_axis_tready = 1'b0;
        s01_axis_tready = 1'b0;
        grant           = 2'b00;
        case (state)
            GRANT0: begin
                m00_axis_tvalid = s00_axis_tvalid;
                m00_axis_tlast  = s00_axis_tlast;
                m00_axis_tdata  = s00_axis_tdata;
                m00_axis_tstrb  = s00_axis_tstrb;
                s00_axis_tready = m00_axis_tready;
                grant           = 2'b01;
            end
            GRANT1: begin
                m00_axis_tvalid = s01_axis_tvalid;
                m00_axis_tlast  = s01_axis_tlast;
                m00_axis_tdata  = s01_axis_tdata;
                m00_axis_tstrb  = s01_axis_tstrb;
                s01_axis_tready = m00_axis_tready;
                grant           = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Self-checking bench for stream_packet_arbiter: packet-level source queues,
// a transaction-level ownership model and per-scenario inline comparisons.
module tb_stream_packet_arbiter;

    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int BW = 2 + 1 + 1 + DW + SW + 1 + 1 + 16 + 16;

    logic          pixel_clk = 1'b0;
    logic          rst;
    logic          s00_axis_tvalid, s00_axis_tlast, s00_axis_tready;
    logic [DW-1:0] s00_axis_tdata;
    logic [SW-1:0] s00_axis_tstrb;
    logic          s01_axis_tvalid, s01_axis_tlast, s01_axis_tready;
    logic [DW-1:0] s01_axis_tdata;
    logic [SW-1:0] s01_axis_tstrb;
    logic          m00_axis_tvalid, m00_axis_tlast, m00_axis_tready;
    logic [DW-1:0] m00_axis_tdata;
    logic [SW-1:0] m00_axis_tstrb;
    logic [1:0]    grant;
    logic [15:0]   pkt_count0, pkt_count1;

    always #5 pixel_clk = ~pixel_clk;

    stream_packet_arbiter #(.C_AXIS_TDATA_WIDTH(DW)) dut (
        .pixel_clk(pixel_clk), .rst(rst),
        .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tlast(s00_axis_tlast),
        .s00_axis_tdata(s00_axis_tdata), .s00_axis_tstrb(s00_axis_tstrb),
        .s00_axis_tready(s00_axis_tready),
        .s01_axis_tvalid(s01_axis_tvalid), .s01_axis_tlast(s01_axis_tlast),
        .s01_axis_tdata(s01_axis_tdata), .s01_axis_tstrb(s01_axis_tstrb),
        .s01_axis_tready(s01_axis_tready),
        .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tlast(m00_axis_tlast),
        .m00_axis_tdata(m00_axis_tdata), .m00_axis_tstrb(m00_axis_tstrb),
        .m00_axis_tready(m00_axis_tready),
        .grant(grant), .pkt_count0(pkt_count0), .pkt_count1(pkt_count1)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    int checks   = 0;
    int failures = 0;

    // Pending beats per requester (whole packets are pushed at once).
    beat_t q0[$];
    beat_t q1[$];

    // Stimulus modes: vmode 0 = tvalid whenever data pending, 1 = random.
    // rmode 0 = tready high, 1 = random, 2 = toggling.
    int   vmode0, vmode1, rmode;
    logic tog;

    // Reference model: owner -1 = nobody, else requester index.
    int          owner;
    int          last_win;
    logic [15:0] m_cnt0, m_cnt1;

    logic [BW-1:0] exp_b, obs_b;

    task automatic push_pkt(input int src, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.strb = SW'($urandom);
            b.last = (i == len - 1);
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
        end
    endtask

    task automatic model_reset();
        owner    = -1;
        last_win = 1;
        m_cnt0   = 16'h0000;
        m_cnt1   = 16'h0000;
        q0.delete();
        q1.delete();
    endtask

    // One clock: drive sources from the queues, snapshot expected and
    // observed outputs mid-cycle, then advance the model at the clock edge.
    // Entered and left at 1 time unit after a rising edge.
    task automatic cycle();
        beat_t b;
        if (q0.size() > 0) begin
            b = q0[0];
            s00_axis_tvalid = (vmode0 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            s00_axis_tdata  = b.data;
            s00_axis_tstrb  = b.strb;
            s00_axis_tlast  = b.last;
        end else begin
            s00_axis_tvalid = 1'b0;
            s00_axis_tdata  = $urandom;
            s00_axis_tstrb  = SW'($urandom);
            s00_axis_tlast  = 1'($urandom_range(0, 1));
        end
        if (q1.size() > 0) begin
            b = q1[0];
            s01_axis_tvalid = (vmode1 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            s01_axis_tdata  = b.data;
            s01_axis_tstrb  = b.strb;
            s01_axis_tlast  = b.last;
        end else begin
            s01_axis_tvalid = 1'b0;
            s01_axis_tdata  = $urandom;
            s01_axis_tstrb  = SW'($urandom);
            s01_axis_tlast  = 1'($urandom_range(0, 1));
        end
        case (rmode)
            0:       m00_axis_tready = 1'b1;
            1:       m00_axis_tready = 1'($urandom_range(0, 1));
            default: begin m00_axis_tready = tog; tog = ~tog; end
        endcase
        #4;
        if (owner == 0)
            exp_b = {2'b01, s00_axis_tvalid, s00_axis_tlast, s00_axis_tdata, s00_axis_tstrb,
                     m00_axis_tready, 1'b0, m_cnt0, m_cnt1};
        else if (owner == 1)
            exp_b = {2'b10, s01_axis_tvalid, s01_axis_tlast, s01_axis_tdata, s01_axis_tstrb,
                     1'b0, m00_axis_tready, m_cnt0, m_cnt1};
        else
            exp_b = {2'b00, 1'b0, 1'b0, {DW{1'b0}}, {SW{1'b0}}, 1'b0, 1'b0, m_cnt0, m_cnt1};
        obs_b = {grant, m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata, m00_axis_tstrb,
                 s00_axis_tready, s01_axis_tready, pkt_count0, pkt_count1};
        @(posedge pixel_clk);
        if (owner == -1) begin
            if (s00_axis_tvalid && s01_axis_tvalid) owner = (last_win == 1) ? 0 : 1;
            else if (s00_axis_tvalid)               owner = 0;
            else if (s01_axis_tvalid)               owner = 1;
        end else if (owner == 0 && s00_axis_tvalid && m00_axis_tready) begin
            b = q0.pop_front();
            if (b.last) begin m_cnt0 = m_cnt0 + 16'd1; last_win = 0; owner = -1; end
        end else if (owner == 1 && s01_axis_tvalid && m00_axis_tready) begin
            b = q1.pop_front();
            if (b.last) begin m_cnt1 = m_cnt1 + 16'd1; last_win = 1; owner = -1; end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s00_axis_tvalid = 1'b0; s00_axis_tlast = 1'b0; s00_axis_tdata = '0; s00_axis_tstrb = '0;
        s01_axis_tvalid = 1'b0; s01_axis_tlast = 1'b0; s01_axis_tdata = '0; s01_axis_tstrb = '0;
        m00_axis_tready = 1'b1;
        vmode0 = 0; vmode1 = 0; rmode = 0; tog = 1'b1;
        model_reset();
        @(posedge pixel_clk);
        #1 rst = 1'b0;
    endtask

    // Reset state with both requesters asserting everything.
    task automatic test_reset();
        logic [22:0] o;
        rst = 1'b1;
        s00_axis_tvalid = 1'b1; s00_axis_tlast = 1'b1; s00_axis_tdata = 32'hA5A5_0001; s00_axis_tstrb = 4'hF;
        s01_axis_tvalid = 1'b1; s01_axis_tlast = 1'b1; s01_axis_tdata = 32'h5A5A_0002; s01_axis_tstrb = 4'hF;
        m00_axis_tready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge pixel_clk);
            #2;
            o = {grant, m00_axis_tvalid, m00_axis_tlast, s00_axis_tready, s01_axis_tready,
                 pkt_count0, pkt_count1[0]};
            checks++;
            if (o !== 23'd0 || pkt_count1 !== 16'd0) begin
                failures++;
                $display("FAIL reset_state k=%0d got=%h cnt1=%h required=0", k, o, pkt_count1);
            end
            checks++;
            if (m00_axis_tdata !== 32'd0) begin
                failures++;
                $display("FAIL reset_tdata got=%h required=0", m00_axis_tdata);
            end
        end
        do_reset();
    endtask

    // Tie from reset: s00 wins, one idle cycle, then s01.
    task automatic test_tie_from_reset();
        logic [1:0] gt [12] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0,
                                2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
        do_reset();
        push_pkt(0, 4);
        push_pkt(1, 4);
        for (int c = 0; c < 12; c++) begin
            cycle();
            checks++;
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL tie_outputs cyc=%0d got=%h required=%h", c, obs_b, exp_b);
            end
            checks++;
            if (obs_b[BW-1 -: 2] !== gt[c]) begin
                failures++;
                $display("FAIL tie_grant cyc=%0d got=%b required=%b", c, obs_b[BW-1 -: 2], gt[c]);
            end
        end
        checks++;
        if (pkt_count0 !== 16'd1 || pkt_count1 !== 16'd1) begin
            failures++;
            $display("FAIL tie_counts got=%0d/%0d required=1/1", pkt_count0, pkt_count1);
        end
    endtask

    // Three back-to-back 2-beat packets from s01 only.
    task automatic test_back_to_back();
        logic [1:0] gt [10] = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd2, 2'd2, 2'd0, 2'd2, 2'd2, 2'd0};
        do_reset();
        for (int p = 0; p < 3; p++) push_pkt(1, 2);
        for (int c = 0; c < 10; c++) begin
            cycle();
            checks++;
            if (obs_b !== exp_b || obs_b[BW-1 -: 2] !== gt[c]) begin
                failures++;
                $display("FAIL b2b cyc=%0d got=%h required=%h grant_req=%b", c, obs_b, exp_b, gt[c]);
            end
        end
        checks++;
        if (pkt_count0 !== 16'd0 || pkt_count1 !== 16'd3) begin
            failures++;
            $display("FAIL b2b_counts got=%0d/%0d required=0/3", pkt_count0, pkt_count1);
        end
    endtask

    // s00 owns the bus while tready toggles and s00 tvalid drops mid-packet;
    // s01 keeps requesting and must be held off until the tlast handshake.
    task automatic test_stall();
        int c;
        do_reset();
        push_pkt(0, 6);
        push_pkt(1, 2);
        rmode = 2;
        c = 0;
        while (q0.size() > 0 && c < 80) begin
            vmode0 = (c == 0) ? 0 : 1;
            cycle();
            checks++;
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL stall_outputs cyc=%0d got=%h required=%h", c, obs_b, exp_b);
            end
            if (c > 0) begin
                checks++;
                if (obs_b[BW-1 -: 2] !== 2'b01 || s01_axis_tready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d grant=%b s01_tready=%b required=01/0",
                             c, obs_b[BW-1 -: 2], s01_axis_tready);
                end
            end
            c++;
        end
        checks++;
        if (q0.size() != 0 || pkt_count0 !== 16'd1 || pkt_count1 !== 16'd0) begin
            failures++;
            $display("FAIL stall_done left=%0d counts=%0d/%0d required=0 1/0", q0.size(), pkt_count0, pkt_count1);
        end
        rmode = 0;
        for (int k = 0; k < 4; k++) cycle();
        checks++;
        if (pkt_count1 !== 16'd1) begin
            failures++;
            $display("FAIL stall_s01_after got=%0d required=1", pkt_count1);
        end
    endtask

    // Random traffic on both ports against the model.
    task automatic test_random();
        int c;
        do_reset();
        for (int p = 0; p < 8; p++) begin
            push_pkt(0, $urandom_range(1, 5));
            push_pkt(1, $urandom_range(1, 5));
        end
        vmode0 = 1; vmode1 = 1; rmode = 1;
        c = 0;
        while ((q0.size() > 0 || q1.size() > 0) && c < 2000) begin
            cycle();
            checks++;
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h required=%h", c, obs_b, exp_b);
            end
            c++;
        end
        cycle();
        checks++;
        if (pkt_count0 !== 16'd8 || pkt_count1 !== 16'd8 || c >= 2000) begin
            failures++;
            $display("FAIL random_counts got=%0d/%0d cycles=%0d required=8/8", pkt_count0, pkt_count1, c);
        end
    endtask

    // Counter wrap: preload near the top, then two single-beat packets.
    task automatic test_wrap();
        do_reset();
        force dut.pkt_count0 = 16'hFFFE;
        #1 release dut.pkt_count0;
        m_cnt0 = 16'hFFFE;
        checks++;
        if (pkt_count0 !== 16'hFFFE) begin
            failures++;
            $display("FAIL wrap_preload got=%h required=fffe", pkt_count0);
        end
        push_pkt(0, 1);
        push_pkt(0, 1);
        for (int c = 0; c < 5; c++) begin
            cycle();
            checks++;
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL wrap_outputs cyc=%0d got=%h required=%h", c, obs_b, exp_b);
            end
            if (c == 1) begin
                checks++;
                if (pkt_count0 !== 16'hFFFF) begin
                    failures++;
                    $display("FAIL wrap_ffff got=%h required=ffff", pkt_count0);
                end
            end
        end
        checks++;
        if (pkt_count0 !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_zero got=%h required=0000", pkt_count0);
        end
    endtask

    // Reset asserted during beat 2 of a 5-beat s01 packet.
    task automatic test_reset_mid();
        logic [1:0] gt [3] = '{2'd0, 2'd1, 2'd0};
        do_reset();
        push_pkt(1, 5);
        for (int c = 0; c < 2; c++) begin
            cycle();
            checks++;
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL rstmid_pre cyc=%0d got=%h required=%h", c, obs_b, exp_b);
            end
        end
        s01_axis_tvalid = 1'b1;
        s01_axis_tdata  = q1[0].data;
        s01_axis_tstrb  = q1[0].strb;
        s01_axis_tlast  = q1[0].last;
        #1;
        checks++;
        if (m00_axis_tvalid !== 1'b1 || m00_axis_tdata !== q1[0].data) begin
            failures++;
            $display("FAIL rstmid_beat2 valid=%b data=%h required=1/%h", m00_axis_tvalid, m00_axis_tdata, q1[0].data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({m00_axis_tvalid, m00_axis_tlast, grant, s00_axis_tready, s01_axis_tready} !== 6'd0 ||
            pkt_count1 !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_async tv=%b tl=%b grant=%b rdy=%b%b cnt1=%0d required=all 0",
                     m00_axis_tvalid, m00_axis_tlast, grant, s00_axis_tready, s01_axis_tready, pkt_count1);
        end
        model_reset();
        @(posedge pixel_clk);
        #1 rst = 1'b0;
        push_pkt(0, 1);
        push_pkt(1, 1);
        for (int c = 0; c < 3; c++) begin
            cycle();
            checks++;
            if (obs_b !== exp_b || obs_b[BW-1 -: 2] !== gt[c]) begin
                failures++;
                $display("FAIL rstmid_post cyc=%0d got=%h required=%h grant_req=%b", c, obs_b, exp_b, gt[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tie_from_reset();
        test_back_to_back();
        test_stall();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
